// File: rtl/game_pkg.sv
// Shared encodings for the duck runner game controller: FSM states and BCD
// score geometry.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam logic [BCD_W*NUM_DIGITS-1:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the game sequencer and its neighbours: debounced buttons,
// frame timing and collision in; game state, pacing and scores out.
interface game_sequencer_if #(
  parameter int SPDW = 4
);
  logic            frame_tick;
  logic            start_pulse;
  logic            pause_pulse;
  logic            collision;
  logic [1:0]      state;
  logic            run;
  logic            frame_step;
  logic            core_rst;
  logic [SPDW-1:0] speed;
  logic [15:0]     score_bcd;
  logic [15:0]     hi_bcd;

  modport master (
    output frame_tick, start_pulse, pause_pulse, collision,
    input  state, run, frame_step, core_rst, speed, score_bcd, hi_bcd
  );

  modport slave (
    input  frame_tick, start_pulse, pause_pulse, collision,
    output state, run, frame_step, core_rst, speed, score_bcd, hi_bcd
  );
endinterface

// File: rtl/game_sequencer_bcd_counter4.sv
// Four-digit packed BCD up-counter that saturates at 9999 and strobes
// hundreds_carry in the cycle an increment rolls xx99 over to (x+1)00.
module bcd_counter4
  import game_pkg::*;
(
  input  logic                        board_clk,
  input  logic                        Reset,
  input  logic                        clr,
  input  logic                        inc,
  output logic [BCD_W*NUM_DIGITS-1:0] value,
  output logic                        hundreds_carry
);

  logic [BCD_W*NUM_DIGITS-1:0] value_r;
  logic [BCD_W*NUM_DIGITS-1:0] next_s;
  logic                        carry_s;
  logic                        at_max_s;

  // Ripple a +1 through the digits, least significant first
  always_comb begin
    next_s  = value_r;
    carry_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!carry_s) begin
        next_s[i*BCD_W +: BCD_W] = value_r[i*BCD_W +: BCD_W];
      end else if (value_r[i*BCD_W +: BCD_W] == 4'd9) begin
        next_s[i*BCD_W +: BCD_W] = 4'd0;
      end else begin
        next_s[i*BCD_W +: BCD_W] = value_r[i*BCD_W +: BCD_W] + 4'd1;
        carry_s                  = 1'b0;
      end
    end
  end

  assign at_max_s = (value_r == BCD_MAX);

  // Combinational strobe so the consumer can update in the same edge as the value
  assign hundreds_carry = inc & ~clr & ~at_max_s & (value_r[7:0] == 8'h99);

  // Count register: clear wins, increments stop at 9999
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      value_r <= 16'h0000;
    end else if (clr) begin
      value_r <= 16'h0000;
    end else if (inc && !at_max_s) begin
      value_r <= next_s;
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/game_sequencer.sv
// Play/pause/game-over controller for the duck runner: gates per-frame core
// advance, keeps BCD score and high score, and paces obstacle speed.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SPEED_INIT   = 2,
  parameter int SPEED_MAX    = 8,
  parameter int SCORE_DIV    = 6,
  parameter int DEATH_FRAMES = 90,
  parameter int SPDW         = 4
) (
  input  logic              board_clk,
  input  logic              Reset,
  game_sequencer_if.slave   bus
);

  localparam int FCW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int LKW = $clog2(DEATH_FRAMES + 1);
  localparam logic [FCW-1:0]  FCNT_LAST = FCW'(SCORE_DIV - 1);
  localparam logic [LKW-1:0]  LOCK_LOAD = LKW'(DEATH_FRAMES);
  localparam logic [SPDW-1:0] SPD_INIT  = SPDW'(SPEED_INIT);
  localparam logic [SPDW-1:0] SPD_MAX   = SPDW'(SPEED_MAX);

  game_state_t     state_r, state_nx_s;
  logic            run_r, frame_step_r, core_rst_r;
  logic            run_nx_s, frame_step_nx_s, core_rst_nx_s;
  logic [SPDW-1:0] speed_r;
  logic [15:0]     hi_r;
  logic [15:0]     score_s;
  logic            carry_s;
  logic [FCW-1:0]  fcnt_r;
  logic [LKW-1:0]  lock_r;
  logic            coll_seen_r;
  logic            tick_run_s, pend_s, die_s, adv_s, start_ok_s, score_inc_s;

  // A collision in the same cycle as the tick still counts for that frame
  assign tick_run_s  = (state_r == ST_RUN) & bus.frame_tick;
  assign pend_s      = coll_seen_r | bus.collision;
  assign die_s       = tick_run_s & pend_s;
  assign adv_s       = tick_run_s & ~pend_s;
  assign start_ok_s  = bus.start_pulse &
                       ((state_r == ST_IDLE) |
                        ((state_r == ST_OVER) & (lock_r == {LKW{1'b0}})));
  assign score_inc_s = adv_s & (fcnt_r == FCNT_LAST);

  bcd_counter4 u_score (
    .board_clk      (board_clk),
    .Reset          (Reset),
    .clr            (start_ok_s),
    .inc            (score_inc_s),
    .value          (score_s),
    .hundreds_carry (carry_s)
  );

  // State register
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; on a tick in RUN the frame is resolved before pausing
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  state_nx_s = start_ok_s ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (die_s) begin
          state_nx_s = ST_OVER;
        end else if (bus.pause_pulse) begin
          state_nx_s = ST_PAUSE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_PAUSE: state_nx_s = bus.pause_pulse ? ST_RUN : ST_PAUSE;
      ST_OVER:  state_nx_s = start_ok_s ? ST_RUN : ST_OVER;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    run_nx_s        = (state_nx_s == ST_RUN);
    frame_step_nx_s = adv_s;
    core_rst_nx_s   = start_ok_s;
  end

  // Output pulses, frame counter, lockout, collision latch, speed and high score
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      run_r        <= 1'b0;
      frame_step_r <= 1'b0;
      core_rst_r   <= 1'b0;
      fcnt_r       <= {FCW{1'b0}};
      lock_r       <= {LKW{1'b0}};
      coll_seen_r  <= 1'b0;
      speed_r      <= SPD_INIT;
      hi_r         <= 16'h0000;
    end else begin
      run_r        <= run_nx_s;
      frame_step_r <= frame_step_nx_s;
      core_rst_r   <= core_rst_nx_s;

      if (start_ok_s) begin
        fcnt_r <= {FCW{1'b0}};
      end else if (adv_s) begin
        fcnt_r <= (fcnt_r == FCNT_LAST) ? {FCW{1'b0}} : fcnt_r + FCW'(1);
      end else begin
        fcnt_r <= fcnt_r;
      end

      if (die_s) begin
        lock_r <= LOCK_LOAD;
      end else if ((state_r == ST_OVER) && bus.frame_tick && (lock_r != {LKW{1'b0}})) begin
        lock_r <= lock_r - LKW'(1);
      end else begin
        lock_r <= lock_r;
      end

      if (start_ok_s || tick_run_s) begin
        coll_seen_r <= 1'b0;
      end else if ((state_r == ST_RUN) && bus.collision) begin
        coll_seen_r <= 1'b1;
      end else begin
        coll_seen_r <= coll_seen_r;
      end

      if (start_ok_s) begin
        speed_r <= SPD_INIT;
      end else if (carry_s && (speed_r < SPD_MAX)) begin
        speed_r <= speed_r + SPDW'(1);
      end else begin
        speed_r <= speed_r;
      end

      if (die_s && (score_s > hi_r)) begin
        hi_r <= score_s;
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  assign bus.state      = state_r;
  assign bus.run        = run_r;
  assign bus.frame_step = frame_step_r;
  assign bus.core_rst   = core_rst_r;
  assign bus.speed      = speed_r;
  assign bus.score_bcd  = score_s;
  assign bus.hi_bcd     = hi_r;

endmodule
